// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register feeding the register-file write port, with freeze, flush and R15 guard.
// Optional retired-instruction counter is built when WB_RETIRE_CNT_EN is defined.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [DATA_W-1:0] pc_in,
  output logic              writebacken,
  output logic [REG_AW-1:0] dest_wb,
  output logic [DATA_W-1:0] result_wb,
  output logic              valid_out,
  output logic [DATA_W-1:0] pc_out,
  output logic              r15_wb_err,
  output logic [31:0]       retired_cnt
);

  localparam logic [REG_AW-1:0] R15_IDX = REG_AW'(15);

  logic [DATA_W-1:0] result;
  logic              wants_write;
  logic              is_r15;
  logic              capture;

  assign result      = mem_r_en_in ? mem_data_in : alu_res_in;
  assign wants_write = valid_in & wb_en_in;
  assign is_r15      = (dest_in == R15_IDX);
  assign capture     = ~flush & ~freeze;

  // The register file has no R15, so such writes are dropped and remembered in a sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out   <= 1'b0;
      writebacken <= 1'b0;
      dest_wb     <= '0;
      result_wb   <= '0;
      pc_out      <= '0;
      r15_wb_err  <= 1'b0;
    end else if (flush) begin
      valid_out   <= 1'b0;
      writebacken <= 1'b0;
      dest_wb     <= '0;
      result_wb   <= '0;
      pc_out      <= '0;
    end else if (!freeze) begin
      valid_out   <= valid_in;
      writebacken <= wants_write & ~is_r15;
      dest_wb     <= dest_in;
      result_wb   <= result;
      pc_out      <= pc_in;
      if (wants_write && is_r15) begin
        r15_wb_err <= 1'b1;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_q;

  // Every real instruction that passes through counts, including dropped R15 writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (capture && valid_in) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors push expectations, a negedge monitor checks them.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        valid_in;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic [31:0] alu_res_in;
  logic [31:0] mem_data_in;
  logic [3:0]  dest_in;
  logic [31:0] pc_in;
  logic        writebacken;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;
  logic        valid_out;
  logic [31:0] pc_out;
  logic        r15_wb_err;
  logic [31:0] retired_cnt;

  mem_wb_stage #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .alu_res_in(alu_res_in), .mem_data_in(mem_data_in), .dest_in(dest_in),
    .pc_in(pc_in), .writebacken(writebacken), .dest_wb(dest_wb),
    .result_wb(result_wb), .valid_out(valid_out), .pc_out(pc_out),
    .r15_wb_err(r15_wb_err), .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic        we;
    logic [3:0]  dest;
    logic [31:0] res;
    logic [31:0] pc;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic check_output(input string vec, input string field,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=0x%08h required=0x%08h", vec, field, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, so each pending expectation is checked at the next falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check_output(e.name, "valid_out",   {31'd0, valid_out},   {31'd0, e.v});
      check_output(e.name, "writebacken", {31'd0, writebacken}, {31'd0, e.we});
      check_output(e.name, "dest_wb",     {28'd0, dest_wb},     {28'd0, e.dest});
      check_output(e.name, "result_wb",   result_wb,            e.res);
      check_output(e.name, "pc_out",      pc_out,               e.pc);
      check_output(e.name, "r15_wb_err",  {31'd0, r15_wb_err},  {31'd0, e.err});
      check_output(e.name, "retired_cnt", retired_cnt,          e.cnt);
    end
  end

  task automatic push_exp(input string name, input logic v, input logic we, input logic [3:0] dest,
                          input logic [31:0] res, input logic [31:0] pc, input logic err);
    exp_t e;
    e.name = name; e.v = v; e.we = we; e.dest = dest; e.res = res; e.pc = pc; e.err = err;
`ifdef WB_RETIRE_CNT_EN
    e.cnt = exp_cnt;
`else
    e.cnt = 32'd0;
`endif
    sb.push_back(e);
  endtask

  // Called just after a falling edge; the expectation is checked on the falling edge after the next capture.
  task automatic apply_stimulus(input string name, input logic frz, input logic fl,
                                input logic vin, input logic wen, input logic mren,
                                input logic [31:0] alu, input logic [31:0] mem,
                                input logic [3:0] dest, input logic [31:0] pc,
                                input logic ev, input logic ewe, input logic [3:0] edest,
                                input logic [31:0] eres, input logic [31:0] epc, input logic eerr);
    freeze = frz; flush = fl; valid_in = vin; wb_en_in = wen; mem_r_en_in = mren;
    alu_res_in = alu; mem_data_in = mem; dest_in = dest; pc_in = pc;
    if (!rst && !fl && !frz && vin) exp_cnt = exp_cnt + 32'd1;
    push_exp(name, ev, ewe, edest, eres, epc, eerr);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 0; flush = 0; valid_in = 0; wb_en_in = 0; mem_r_en_in = 0;
    alu_res_in = 0; mem_data_in = 0; dest_in = 0; pc_in = 0;
    @(negedge clk); #1;

    apply_stimulus("reset_init", 0,0, 1,1,0, 32'h12,32'h0, 4'd3,32'h50, 0,0,4'd0,32'h0,32'h0,0);
    rst = 1'b0;
    apply_stimulus("first_write", 0,0, 1,1,0, 32'h12,32'h0, 4'd3,32'h100, 1,1,4'd3,32'h12,32'h100,0);
    apply_stimulus("load_select", 0,0, 1,1,1, 32'h100,32'hDEADBEEF, 4'd7,32'h104, 1,1,4'd7,32'hDEADBEEF,32'h104,0);
    apply_stimulus("cap_5", 0,0, 1,1,0, 32'hAA,32'h0, 4'd5,32'h108, 1,1,4'd5,32'hAA,32'h108,0);
    for (int i = 0; i < 3; i++)
      apply_stimulus("freeze_hold", 1,0, 1,1,0, 32'hBB,32'h0, 4'd6,32'h10C, 1,1,4'd5,32'hAA,32'h108,0);
    apply_stimulus("flush_over_freeze", 1,1, 1,1,0, 32'hBB,32'h0, 4'd6,32'h10C, 0,0,4'd0,32'h0,32'h0,0);
    apply_stimulus("r15_drop", 0,0, 1,1,0, 32'h55,32'h0, 4'd15,32'h110, 1,0,4'd15,32'h55,32'h110,1);
    apply_stimulus("err_sticky", 0,0, 1,1,0, 32'h77,32'h0, 4'd4,32'h114, 1,1,4'd4,32'h77,32'h114,1);
    apply_stimulus("bubble", 0,0, 0,1,0, 32'h99,32'h0, 4'd2,32'h118, 0,0,4'd2,32'h99,32'h118,1);
    apply_stimulus("no_wb_en", 0,0, 1,0,0, 32'h1,32'h0, 4'd9,32'h11C, 1,0,4'd9,32'h1,32'h11C,1);
    apply_stimulus("flush_only", 0,1, 1,1,0, 32'h2,32'h0, 4'd1,32'h120, 0,0,4'd0,32'h0,32'h0,1);
    apply_stimulus("pre_reset", 0,0, 1,1,0, 32'h33,32'h0, 4'd8,32'h124, 1,1,4'd8,32'h33,32'h124,1);

    // Mid-cycle asynchronous reset with valid data still applied.
    @(posedge clk); #2;
    rst = 1'b1;
    exp_cnt = 32'd0;
    push_exp("reset_async", 0,0,4'd0,32'h0,32'h0,0);
    @(negedge clk); #1;
    apply_stimulus("reset_hold", 0,0, 1,1,0, 32'h33,32'h0, 4'd8,32'h124, 0,0,4'd0,32'h0,32'h0,0);
    rst = 1'b0;
    apply_stimulus("post_reset", 0,0, 1,1,0, 32'h12,32'h0, 4'd3,32'h200, 1,1,4'd3,32'h12,32'h200,0);

    // Counter run: 10 valid captures mixed with 2 freezes and 1 flush.
    for (int i = 0; i < 9; i++)
      apply_stimulus("cnt_cap", 0,0, 1,1,0, 32'(i),32'h0, 4'd1,32'h300, 1,1,4'd1,32'(i),32'h300,0);
    apply_stimulus("cnt_freeze", 1,0, 1,1,0, 32'hF0,32'h0, 4'd2,32'h304, 1,1,4'd1,32'd8,32'h300,0);
    apply_stimulus("cnt_freeze", 1,0, 1,1,0, 32'hF0,32'h0, 4'd2,32'h304, 1,1,4'd1,32'd8,32'h300,0);
    apply_stimulus("cnt_flush", 0,1, 1,1,0, 32'hF0,32'h0, 4'd2,32'h304, 0,0,4'd0,32'h0,32'h0,0);

`ifdef WB_RETIRE_CNT_EN
    if (exp_cnt != 32'd10) $display("[TB] note: counter model at %0d", exp_cnt);
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    exp_cnt = 32'hFFFFFFFF;
`endif
    apply_stimulus("cnt_wrap", 0,0, 1,1,0, 32'h42,32'h0, 4'd6,32'h308, 1,1,4'd6,32'h42,32'h308,0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and write-back select for the ARM core.
- Captures memory-stage results on the rising clock edge and drives the register file write port (dest_wb, result_wb, writebacken) directly.
- The register file writes on the falling edge, so a value registered here is written half a cycle later.
- Supports freeze (stall), flush (bubble insertion) and R15 write suppression, because the register file holds R0..R14 only.

Parameters:
- DATA_W, 32, datapath width for ALU result, memory data and PC.
- REG_AW, 4, register address width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- freeze  input  1  hold all stage registers.
- flush  input  1  replace the incoming instruction with a bubble.
- valid_in  input  1  the memory stage holds a real instruction.
- wb_en_in  input  1  the instruction writes a register.
- mem_r_en_in  input  1  the instruction is a load; select mem_data_in.
- alu_res_in  input  DATA_W  ALU/address result.
- mem_data_in  input  DATA_W  load data from memory.
- dest_in  input  REG_AW  destination register index.
- pc_in  input  DATA_W  instruction PC, kept for debug.
- writebacken  output  1  register-file write enable.
- dest_wb  output  REG_AW  register-file write address.
- result_wb  output  DATA_W  register-file write data.
- valid_out  output  1  the stage holds a real instruction.
- pc_out  output  DATA_W  PC of the held instruction.
- r15_wb_err  output  1  sticky flag: a valid write to R15 was dropped.
- retired_cnt  output  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (async, rst=1): all outputs go to 0 immediately and hold at 0 while rst stays high. No write occurs during reset.
- All outputs are registered; there is no combinational path from inputs to outputs. Latency is 1 cycle from the input sample edge to the output.
- Write-back mux before the register: result = mem_r_en_in ? mem_data_in : alu_res_in. The full DATA_W bits pass through with no extension.
- Normal capture (rst=0, flush=0, freeze=0), on the rising edge:
  - valid_out <= valid_in.
  - writebacken <= valid_in & wb_en_in & (dest_in != 15).
  - dest_wb <= dest_in.
  - result_wb <= result.
  - pc_out <= pc_in.
- Flush (flush=1): valid_out and writebacken load 0. dest_wb, result_wb and pc_out load 0. Flush takes priority over freeze.
- Freeze (freeze=1, flush=0): all registers hold, including writebacken. A held write is repeated to the same register with the same data, which is harmless.
- R15 guard: if valid_in & wb_en_in & dest_in==15 is captured (normal capture only), writebacken stays 0 and r15_wb_err sets to 1. r15_wb_err clears only on reset.
- Bubble: valid_in=0 gives writebacken=0 regardless of wb_en_in. dest_wb and result_wb still load the input values; they are don't-care for the register file.
- Reset mid-operation: an in-flight instruction is discarded and not written. The first capture after rst falls is on the next rising edge.
- rst and freeze/flush are never sampled together; reset dominates all other inputs.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - retired_cnt is a 32-bit counter, reset to 0.
  - It increments by 1 on each rising edge where a normal capture occurs with valid_in=1. Captures into R15 that are dropped still count.
  - It does not change on freeze or flush.
  - It wraps from 0xFFFFFFFF to 0x00000000.
- Not defined: retired_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset: assert rst mid-cycle with valid data held -> all outputs read 0 before the next edge. Release rst, apply valid_in=1, wb_en_in=1, dest_in=3, alu_res_in=0x12 -> after 1 edge, writebacken=1, dest_wb=3, result_wb=0x12.
- Load select: mem_r_en_in=1, mem_data_in=0xDEADBEEF, alu_res_in=0x100, dest_in=7 -> result_wb=0xDEADBEEF, dest_wb=7, writebacken=1.
- Freeze/flush: capture dest=5/data=0xAA, then freeze=1 for 3 cycles with new inputs dest=6/data=0xBB -> outputs stay dest_wb=5, result_wb=0xAA. Then flush=1 with freeze=1 -> valid_out=0, writebacken=0.
- R15 guard: valid_in=1, wb_en_in=1, dest_in=15 -> writebacken=0, r15_wb_err=1. r15_wb_err stays 1 through subsequent normal writes until rst.
- Bubble: valid_in=0, wb_en_in=1, dest_in=2 -> writebacken=0, valid_out=0.
- Counter (WB_RETIRE_CNT_EN defined): 10 valid captures, 2 freeze cycles and 1 flush -> retired_cnt=10. Force the count to 0xFFFFFFFF, then 1 valid capture -> retired_cnt=0.
